// File: rtl/mac_rx_udp_if.sv
// mac_rx_udp_if -- bundle of RMII receive inputs and UDP payload stream outputs
// for mac_rx_udp.
//   I_rxd / I_crs_dv : RMII receive dibit and carrier-sense/data-valid
//   O_data / O_data_valid / O_sof / O_eof : payload byte stream
//   O_data_len / O_src_ip / O_src_port    : per-frame metadata, updated with O_sof
//   O_done / O_frame_ok / O_busy          : frame completion and activity status
// slave  : the receiver (consumes RMII, drives the stream)
// master : the RMII source / stream sink side
interface mac_rx_udp_if;
    logic [1:0]  I_rxd;
    logic        I_crs_dv;
    logic [7:0]  O_data;
    logic        O_data_valid;
    logic        O_sof;
    logic        O_eof;
    logic [15:0] O_data_len;
    logic [31:0] O_src_ip;
    logic [15:0] O_src_port;
    logic        O_done;
    logic        O_frame_ok;
    logic        O_busy;

    modport slave (
        input  I_rxd, I_crs_dv,
        output O_data, O_data_valid, O_sof, O_eof, O_data_len, O_src_ip,
               O_src_port, O_done, O_frame_ok, O_busy
    );

    modport master (
        output I_rxd, I_crs_dv,
        input  O_data, O_data_valid, O_sof, O_eof, O_data_len, O_src_ip,
               O_src_port, O_done, O_frame_ok, O_busy
    );
endinterface

// File: rtl/mac_rx_udp.sv
// mac_rx_udp -- RMII (100 Mb/s) receive MAC with Ethernet/IPv4/UDP filtering.
// Assembles dibits into bytes, strips preamble/SFD, checks destination MAC
// (local or broadcast), EtherType, IPv4 version/IHL, protocol, destination IP
// and UDP destination port, then streams the UDP payload one byte per strobe.
// Ports:
//   I_clk50m : RMII reference clock (sole clock)
//   I_rst    : asynchronous active-low reset
//   rx       : mac_rx_udp_if.slave (RMII inputs, payload stream, status)
// Optional feature macro: MAC_RX_FCS_CHECK_EN -- when defined, a CRC-32 over
// the frame gates O_frame_ok; when undefined O_frame_ok is 1 for every
// complete accepted frame.
module mac_rx_udp #(
    parameter logic [47:0] mac_my_adr  = 48'he86a64fad17b,
    parameter logic [31:0] ip_my_adr   = {8'd192, 8'd168, 8'd15, 8'd14},
    parameter logic [15:0] udp_my_port = 16'd11451
) (
    input  logic        I_clk50m,
    input  logic        I_rst,
    mac_rx_udp_if.slave rx
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_TAIL, S_DROP
    } state_e;

    // Byte views of the local addresses; index 5 / 3 is the first byte on the wire.
    localparam logic [5:0][7:0] MAC_B = mac_my_adr;
    localparam logic [3:0][7:0] IP_B  = ip_my_adr;

    state_e      state_q, state_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        uc_q, uc_d, bc_q, bc_d;
    logic [31:0] sip_q, sip_d;
    logic [15:0] sport_q, sport_d;
    logic [15:0] ulen_q, ulen_d;

    logic [7:0]  data_q, data_d;
    logic        dv_q, dv_d, sof_q, sof_d, eof_q, eof_d;
    logic [15:0] len_q, len_d;
    logic [31:0] oip_q, oip_d;
    logic [15:0] oport_q, oport_d;
    logic        done_q, done_d, ok_q, ok_d, busy_q, busy_d;

    logic        in_frame, eof_det, shift, byte_done, hdr_bad, fcs_ok;
    logic [7:0]  nb;
    logic [15:0] plen;

    assign in_frame  = (state_q != S_IDLE) && (state_q != S_PREAMBLE);
    // End of frame is only recognised on a byte boundary; a partial byte is dropped.
    assign eof_det   = in_frame && (dcnt_q == 2'd0) && !rx.I_crs_dv;
    assign shift     = in_frame && !eof_det;
    assign nb        = {rx.I_rxd, sh_q[7:2]};
    assign byte_done = shift && (dcnt_q == 2'd3);
    assign plen      = ulen_q - 16'd8;

`ifdef MAC_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_rev;

    // Reflected CRC-32, two bits per clock, LSB of the dibit first.
    always_comb begin
        crc_d   = crc_q;
        crc_rev = '0;
        if (state_q == S_PREAMBLE) begin
            crc_d = '1;
        end else if (shift) begin
            for (int i = 0; i < 2; i++)
                crc_d = (crc_d >> 1) ^ ((crc_d[0] ^ rx.I_rxd[i]) ? 32'hEDB88320 : 32'h0);
        end
        // The good-frame residue is quoted in non-reflected bit order.
        for (int i = 0; i < 32; i++)
            crc_rev[i] = crc_q[31-i];
    end

    always_ff @(posedge I_clk50m or negedge I_rst) begin
        if (!I_rst) crc_q <= '1;
        else        crc_q <= crc_d;
    end

    assign fcs_ok = (crc_rev == 32'hC704DD7B);
`else
    assign fcs_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        uc_d    = uc_q;
        bc_d    = bc_q;
        sip_d   = sip_q;
        sport_d = sport_q;
        ulen_d  = ulen_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        len_d   = len_q;
        oip_d   = oip_q;
        oport_d = oport_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        busy_d  = busy_q;
        hdr_bad = 1'b0;

        if (shift) begin
            sh_d   = nb;
            dcnt_d = dcnt_q + 2'd1;
        end
        if (byte_done)
            bcnt_d = bcnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (rx.I_crs_dv && rx.I_rxd == 2'b01)
                    state_d = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (!rx.I_crs_dv) begin
                    state_d = S_IDLE;
                end else if (rx.I_rxd == 2'b11) begin
                    state_d = S_ETH_HDR;
                    dcnt_d  = '0;
                    bcnt_d  = '0;
                    uc_d    = 1'b1;
                    bc_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (rx.I_rxd != 2'b01) begin
                    state_d = S_IDLE;
                end
            end
            S_ETH_HDR: begin
                if (eof_det) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (byte_done) begin
                    // Unicast and broadcast are tracked separately so a mixed
                    // address (part local, part ff) is rejected.
                    if (bcnt_q < 16'd6) begin
                        uc_d    = uc_q && (nb == MAC_B[3'd5 - bcnt_q[2:0]]);
                        bc_d    = bc_q && (nb == 8'hFF);
                        hdr_bad = !(uc_d || bc_d);
                    end
                    if (bcnt_q == 16'd12 && nb != 8'h08) hdr_bad = 1'b1;
                    if (bcnt_q == 16'd13 && nb != 8'h00) hdr_bad = 1'b1;
                    if (hdr_bad) begin
                        state_d = S_DROP;
                    end else if (bcnt_q == 16'd13) begin
                        state_d = S_IP_HDR;
                        bcnt_d  = '0;
                    end
                end
            end
            S_IP_HDR: begin
                if (eof_det) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (byte_done) begin
                    if (bcnt_q == 16'd0 && nb != 8'h45) hdr_bad = 1'b1;
                    if (bcnt_q == 16'd9 && nb != 8'd17) hdr_bad = 1'b1;
                    if (bcnt_q >= 16'd12 && bcnt_q <= 16'd15)
                        sip_d = {sip_q[23:0], nb};
                    if (bcnt_q >= 16'd16 && nb != IP_B[2'd3 - bcnt_q[1:0]])
                        hdr_bad = 1'b1;
                    if (hdr_bad) begin
                        state_d = S_DROP;
                    end else if (bcnt_q == 16'd19) begin
                        state_d = S_UDP_HDR;
                        bcnt_d  = '0;
                    end
                end
            end
            S_UDP_HDR: begin
                if (eof_det) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (byte_done) begin
                    if (bcnt_q <= 16'd1)
                        sport_d = {sport_q[7:0], nb};
                    if (bcnt_q == 16'd2 && nb != udp_my_port[15:8]) hdr_bad = 1'b1;
                    if (bcnt_q == 16'd3 && nb != udp_my_port[7:0])  hdr_bad = 1'b1;
                    if (bcnt_q == 16'd4 || bcnt_q == 16'd5)
                        ulen_d = {ulen_q[7:0], nb};
                    // Zero-length payload would leave nothing to strobe.
                    if (bcnt_q == 16'd5 && {ulen_q[7:0], nb} < 16'd9) hdr_bad = 1'b1;
                    if (hdr_bad) begin
                        state_d = S_DROP;
                    end else if (bcnt_q == 16'd7) begin
                        state_d = S_PAYLOAD;
                        bcnt_d  = '0;
                    end
                end
            end
            S_PAYLOAD: begin
                if (eof_det) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (byte_done) begin
                    dv_d   = 1'b1;
                    data_d = nb;
                    if (bcnt_q == 16'd0) begin
                        sof_d   = 1'b1;
                        len_d   = plen;
                        oip_d   = sip_q;
                        oport_d = sport_q;
                    end
                    if (bcnt_q == plen - 16'd1) begin
                        eof_d   = 1'b1;
                        state_d = S_TAIL;
                        bcnt_d  = '0;
                    end
                end
            end
            S_TAIL: begin
                if (eof_det) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ok_d    = fcs_ok;
                    busy_d  = 1'b0;
                end
            end
            S_DROP: begin
                if (eof_det) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk50m or negedge I_rst) begin
        if (!I_rst) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            uc_q    <= 1'b0;
            bc_q    <= 1'b0;
            sip_q   <= '0;
            sport_q <= '0;
            ulen_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            len_q   <= '0;
            oip_q   <= '0;
            oport_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            uc_q    <= uc_d;
            bc_q    <= bc_d;
            sip_q   <= sip_d;
            sport_q <= sport_d;
            ulen_q  <= ulen_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            len_q   <= len_d;
            oip_q   <= oip_d;
            oport_q <= oport_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            busy_q  <= busy_d;
        end
    end

    assign rx.O_data       = data_q;
    assign rx.O_data_valid = dv_q;
    assign rx.O_sof        = sof_q;
    assign rx.O_eof        = eof_q;
    assign rx.O_data_len   = len_q;
    assign rx.O_src_ip     = oip_q;
    assign rx.O_src_port   = oport_q;
    assign rx.O_done       = done_q;
    assign rx.O_frame_ok   = ok_q;
    assign rx.O_busy       = busy_q;
endmodule

// File: tb/tb_mac_rx_udp.sv
// tb_mac_rx_udp -- scoreboard bench for mac_rx_udp. Stimulus builds whole
// RMII frames (preamble, headers, payload 0x00..0x09, padding, FCS) and pushes
// the expected payload strobes / completion results into queues; a monitor on
// the falling clock edge pops and compares whenever the DUT strobes.
module tb_mac_rx_udp;
    localparam logic [47:0] MY_MAC   = 48'he86a64fad17b;
    localparam logic [47:0] BAD_MAC  = 48'h0600aabb0cdd;
    localparam logic [47:0] BC_MAC   = 48'hffffffffffff;
    localparam logic [15:0] EXP_LEN  = 16'd10;
    localparam logic [15:0] EXP_PORT = 16'd5000;
    localparam logic [31:0] EXP_IP   = 32'hc0a80f64;
    // IPv4 header (20 B) + UDP header (8 B): 192.168.15.100:5000 -> 192.168.15.14:11451, UDP len 18
    localparam logic [223:0] IPUDP = {
        8'h45, 8'h00, 8'h00, 8'h26, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
        8'h00, 8'h00, 8'hc0, 8'ha8, 8'h0f, 8'h64, 8'hc0, 8'ha8, 8'h0f, 8'h0e,
        8'h13, 8'h88, 8'h2c, 8'hbb, 8'h00, 8'h12, 8'h00, 8'h00};

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_byte_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_rx_udp_if bus();
    mac_rx_udp dut (.I_clk50m(clk), .I_rst(rst_n), .rx(bus));

    exp_byte_t  exp_q[$];
    logic       exp_done_q[$];
    logic [7:0] frm[$];
    logic [1:0] dib[$];
    int checks = 0;
    int errors = 0;
    exp_byte_t e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, frm[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Builds frm[] and dib[] for one frame; 288 dibits in total.
    // Payload byte k occupies dibits 200+4k .. 203+4k.
    task automatic build_frame(input logic [47:0] dst, input bit bad_fcs);
        logic [47:0]  d;
        logic [223:0] t;
        logic [31:0]  fcs;
        logic [7:0]   b;
        frm.delete();
        dib.delete();
        d = dst;
        repeat (6) begin frm.push_back(d[47:40]); d = d << 8; end
        d = 48'h020000000001;
        repeat (6) begin frm.push_back(d[47:40]); d = d << 8; end
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        t = IPUDP;
        repeat (28) begin frm.push_back(t[223:216]); t = t << 8; end
        for (int i = 0; i < 10; i++) frm.push_back(8'(i));
        repeat (8) frm.push_back(8'h00);
        fcs = crc32(frm.size());
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(bad_fcs ? (fcs[31:24] ^ 8'h01) : fcs[31:24]);
        repeat (31) dib.push_back(2'b01);
        dib.push_back(2'b11);
        foreach (frm[i]) begin
            b = frm[i];
            dib.push_back(b[1:0]);
            dib.push_back(b[3:2]);
            dib.push_back(b[5:4]);
            dib.push_back(b[7:6]);
        end
    endtask

    task automatic push_exp(input int nbytes, input bit full, input bit has_done, input bit ok);
        exp_byte_t x;
        for (int i = 0; i < nbytes; i++) begin
            x.data = 8'(i);
            x.sof  = (i == 0);
            x.eof  = full && (i == 9);
            exp_q.push_back(x);
        end
        if (has_done) exp_done_q.push_back(ok);
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            bus.I_crs_dv = 1'b1;
            bus.I_rxd    = dib[i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.I_crs_dv = 1'b0;
            bus.I_rxd    = 2'b00;
        end
    endtask

    task automatic check_drained(input string name);
        check({name, "_bytes_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_left"}, 64'(exp_done_q.size()), 64'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.O_data_valid && (bus.O_sof || bus.O_eof))
                check("flag_without_valid", {62'd0, bus.O_sof, bus.O_eof}, 64'd0);
            if (bus.O_data_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got data %0h, none expected at %0t", bus.O_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(bus.O_data), 64'(e.data));
                    check("sof", 64'(bus.O_sof), 64'(e.sof));
                    check("eof", 64'(bus.O_eof), 64'(e.eof));
                    if (e.sof) begin
                        check("data_len", 64'(bus.O_data_len), 64'(EXP_LEN));
                        check("src_port", 64'(bus.O_src_port), 64'(EXP_PORT));
                        check("src_ip", 64'(bus.O_src_ip), 64'(EXP_IP));
                    end
                end
            end
            if (bus.O_done) begin
                check("done_with_eof", 64'(bus.O_eof), 64'd0);
                check("done_after_bytes", 64'(exp_q.size()), 64'd0);
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got frame_ok %0b, no done expected at %0t", bus.O_frame_ok, $time);
                end else begin
                    check("frame_ok", 64'(bus.O_frame_ok), 64'(exp_done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.I_crs_dv = 1'b0;
        bus.I_rxd    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_meta", {bus.O_data_len, bus.O_src_ip, bus.O_src_port}, 64'd0);
        check("reset_ctrl", {50'd0, bus.O_data, bus.O_data_valid, bus.O_sof, bus.O_eof,
                             bus.O_done, bus.O_frame_ok, bus.O_busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // 1: valid unicast frame
        build_frame(MY_MAC, 1'b0);
        push_exp(10, 1'b1, 1'b1, 1'b1);
        send_range(0, 220);
        check("busy_mid_payload", 64'(bus.O_busy), 64'd1);
        send_range(220, 288);
        idle(12);
        check("busy_after_good", 64'(bus.O_busy), 64'd0);
        check_drained("good");

        // 2: foreign destination MAC is dropped silently
        build_frame(BAD_MAC, 1'b0);
        send_range(0, 100);
        check("busy_in_drop", 64'(bus.O_busy), 64'd1);
        send_range(100, 288);
        idle(12);
        check("busy_after_drop", 64'(bus.O_busy), 64'd0);
        check_drained("drop");

        // 3: broadcast destination is accepted
        build_frame(BC_MAC, 1'b0);
        push_exp(10, 1'b1, 1'b1, 1'b1);
        send_range(0, 288);
        idle(12);
        check_drained("bcast");

        // 4: corrupted FCS still delivers payload; frame_ok depends on CRC build
        build_frame(MY_MAC, 1'b1);
`ifdef MAC_RX_FCS_CHECK_EN
        push_exp(10, 1'b1, 1'b1, 1'b0);
`else
        push_exp(10, 1'b1, 1'b1, 1'b1);
`endif
        send_range(0, 288);
        idle(12);
        check_drained("badfcs");

        // 5: carrier lost after 5th payload byte
        build_frame(MY_MAC, 1'b0);
        push_exp(5, 1'b0, 1'b1, 1'b0);
        send_range(0, 220);
        idle(12);
        check("busy_after_trunc", 64'(bus.O_busy), 64'd0);
        check_drained("trunc");

        // 6: async reset inside payload byte 3, remainder of payload still on the wire
        build_frame(MY_MAC, 1'b0);
        push_exp(2, 1'b0, 1'b0, 1'b0);
        send_range(0, 210);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_meta", {bus.O_data_len, bus.O_src_ip, bus.O_src_port}, 64'd0);
        check("midreset_ctrl", {50'd0, bus.O_data, bus.O_data_valid, bus.O_sof, bus.O_eof,
                                bus.O_done, bus.O_frame_ok, bus.O_busy}, 64'd0);
        send_range(210, 212);
        rst_n = 1'b1;
        send_range(212, 240);
        idle(12);
        check("busy_after_reset", 64'(bus.O_busy), 64'd0);
        check_drained("reset");

        // 7: reception after reset matches the first case
        build_frame(MY_MAC, 1'b0);
        push_exp(10, 1'b1, 1'b1, 1'b1);
        send_range(0, 288);
        idle(12);
        check_drained("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
